// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 slave register file: oversampled sclk/ncs/sdi, write commit on ncs rise,
// snapshotted readback on sdo, and frame-error pulses for malformed frames.
module spi_regfile_peripheral #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
    parameter int SYNC_STG = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         sdi,
    output logic                         sdo,
    output logic                         sdo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FLEN  = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FLEN + 2);

    logic [SYNC_STG-1:0] sclk_sync;
    logic [SYNC_STG-1:0] ncs_sync;
    logic [SYNC_STG-1:0] sdi_sync;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FLEN-1:0]     shift;
    logic [DATA_W-1:0]   rd_shift;
    logic                rd_act;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Edges are judged between the two oldest synchroniser stages.
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_low, sdi_s;
    assign sclk_rise = sclk_sync[SYNC_STG-2] & ~sclk_sync[SYNC_STG-1];
    assign sclk_fall = ~sclk_sync[SYNC_STG-2] & sclk_sync[SYNC_STG-1];
    assign ncs_rise  = ncs_sync[SYNC_STG-2] & ~ncs_sync[SYNC_STG-1];
    assign ncs_fall  = ~ncs_sync[SYNC_STG-2] & ncs_sync[SYNC_STG-1];
    assign ncs_low   = ~ncs_sync[SYNC_STG-1];
    assign sdi_s     = sdi_sync[SYNC_STG-1];

    logic              frm_rw;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;
    logic              wr_hit;
    assign frm_rw   = shift[FLEN-1];
    assign frm_addr = shift[FLEN-2 -: ADDR_W];
    assign frm_data = shift[DATA_W-1:0];
    assign rd_addr  = shift[ADDR_W-1:0];

    always_comb begin
        rd_val = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ADDR_W'(i) == rd_addr) rd_val = regs[i];
            if (ADDR_W'(i) == frm_addr) wr_hit = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_o[gi*DATA_W +: DATA_W] = regs[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            sdi_sync  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            rd_act    <= 1'b0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STG-2:0], ncs};
            sdi_sync  <= {sdi_sync[SYNC_STG-2:0], sdi};
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            if (ncs_fall) begin
                bit_cnt <= '0;
                shift   <= '0;
                rd_act  <= 1'b0;
                sdo     <= 1'b0;
                sdo_oe  <= 1'b0;
            end else if (ncs_rise) begin
                rd_act <= 1'b0;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
                if (bit_cnt == CNT_W'(FLEN)) begin
                    if (frm_rw && wr_hit) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (ADDR_W'(i) == frm_addr) regs[i] <= frm_data;
                        wr_strobe <= 1'b1;
                        wr_addr   <= frm_addr;
                    end
                end else if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else if (ncs_low) begin
                if (sclk_rise) begin
                    shift <= {shift[FLEN-2:0], sdi_s};
                    if (bit_cnt != CNT_W'(FLEN + 1)) bit_cnt <= bit_cnt + 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == CNT_W'(1 + ADDR_W) && !shift[ADDR_W] && !rd_act) begin
                        // Snapshot the register so a read returns one coherent value.
                        rd_act   <= 1'b1;
                        sdo_oe   <= 1'b1;
                        sdo      <= rd_val[DATA_W-1];
                        rd_shift <= rd_val << 1;
                    end else if (rd_act) begin
                        sdo      <= rd_shift[DATA_W-1];
                        rd_shift <= rd_shift << 1;
                    end
                end
            end else begin
                rd_act <= 1'b0;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral: a host-side SPI driver, a write-commit
// scoreboard fed by the stimulus, and an expected-register model.
module tb_spi_regfile_peripheral;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int NUM_REGS = 5;
    localparam int SYNC_STG = 2;
    localparam int FLEN = 1 + ADDR_W + DATA_W;
    localparam int HALF = 6;
    localparam int MIN_GAP = SYNC_STG + 2;
    localparam logic [NUM_REGS*DATA_W-1:0] RST_IMG = 40'h00_3C_00_5A_00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic ncs = 1'b1;
    logic sdi = 1'b0;
    logic sdo, sdo_oe, wr_strobe, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic [ADDR_W-1:0] wr_addr;

    spi_regfile_peripheral #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .RESET_VAL(RST_IMG), .SYNC_STG(SYNC_STG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .regs_o(regs_o), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic prev_strobe = 1'b0;
    logic [ADDR_W-1:0] strobe_q[$];
    logic rd_q[$];
    logic [NUM_REGS*DATA_W-1:0] exp_regs = RST_IMG;

    // Commit monitor: every strobe must match an address queued by the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_cnt++;
            if (wr_strobe) begin
                tests++;
                if (prev_strobe) begin
                    fails++;
                    $display("FAIL strobe_width got 2+ cycles required 1");
                end else if (strobe_q.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_unexpected got addr %0d required none", wr_addr);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = strobe_q.pop_front();
                    if (wr_addr !== e) begin
                        fails++;
                        $display("FAIL wr_addr got %0d required %0d", wr_addr, e);
                    end
                end
            end
        end
        prev_strobe = wr_strobe;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] frame(input logic rw, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d);
        return 64'({rw, a, d});
    endfunction

    // Sends nbits MSB first; for reads, compares sdo against rd_q before each data rise.
    task automatic xfer(input string name, input int nbits, input logic [63:0] bits,
                        input bit chk_rd, input int gap, input int abort_at);
        ncs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sdi = bits[nbits-1-i];
            wait_clks(HALF);
            if (i == abort_at) begin
                ncs = 1'b1;
                rst_n = 1'b0;
                wait_clks(3);
                rst_n = 1'b1;
                wait_clks(10);
                $display("[TB] %s: reset asserted after %0d bits", name, i);
                return;
            end
            if (chk_rd && i >= 1 + ADDR_W && rd_q.size() > 0) begin
                logic e;
                e = rd_q.pop_front();
                tests++;
                if ({sdo_oe, sdo} !== {1'b1, e}) begin
                    fails++;
                    $display("FAIL %s_bit%0d got oe=%b sdo=%b required oe=1 sdo=%b",
                             name, i - 1 - ADDR_W, sdo_oe, sdo, e);
                end
            end
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
        if (chk_rd) begin
            tests++;
            if (sdo !== 1'b0) begin
                fails++;
                $display("FAIL %s_tail got sdo=%b required 0", name, sdo);
            end
        end
        ncs = 1'b1;
        sdi = 1'b0;
        wait_clks(gap);
        $display("[TB] %s: %0d bits sent, frame=0x%0h", name, nbits, bits);
    endtask

    task automatic check_after(input string name, input int err_before, input int err_delta);
        tests++;
        if (regs_o !== exp_regs) begin
            fails++;
            $display("FAIL %s_regs got 0x%0h required 0x%0h", name, regs_o, exp_regs);
        end
        tests++;
        if (err_cnt - err_before !== err_delta) begin
            fails++;
            $display("FAIL %s_frame_err got %0d required %0d", name, err_cnt - err_before, err_delta);
        end
        tests++;
        if (strobe_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_strobe_missing got 0 strobes required %0d", name, strobe_q.size());
            strobe_q.delete();
        end
    endtask

    task automatic do_write(input string name, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int gap);
        int eb;
        eb = err_cnt;
        if (a < NUM_REGS) begin
            strobe_q.push_back(a);
            exp_regs[a*DATA_W +: DATA_W] = d;
        end
        xfer(name, FLEN, frame(1'b1, a, d), 1'b0, gap, -1);
        check_after(name, eb, 0);
    endtask

    task automatic do_read(input string name, input logic [ADDR_W-1:0] a, input int gap);
        logic [DATA_W-1:0] v;
        int eb;
        eb = err_cnt;
        v = (a < NUM_REGS) ? exp_regs[a*DATA_W +: DATA_W] : '0;
        for (int b = DATA_W - 1; b >= 0; b--) rd_q.push_back(v[b]);
        xfer(name, FLEN, frame(1'b0, a, DATA_W'($urandom)), 1'b1, gap, -1);
        tests++;
        if (rd_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_rd_bits got %0d unchecked required 0", name, rd_q.size());
            rd_q.delete();
        end
        check_after(name, eb, 0);
    endtask

    task automatic test_reset();
        wait_clks(3);
        tests++;
        if ({sdo, sdo_oe, wr_strobe, frame_err} !== 4'b0 || wr_addr !== '0 || regs_o !== RST_IMG) begin
            fails++;
            $display("FAIL reset_state got sdo=%b oe=%b st=%b fe=%b wa=%0d regs=0x%0h required zeros regs=0x%0h",
                     sdo, sdo_oe, wr_strobe, frame_err, wr_addr, regs_o, RST_IMG);
        end
        rst_n = 1'b1;
        wait_clks(5);
        $display("[TB] test_reset: regs_o=0x%0h", regs_o);
        do_read("reset_read_a1", 7'd1, 20);
    endtask

    task automatic test_write_read();
        do_write("write_a2", 7'd2, 8'hA5, 20);
        tests++;
        if (regs_o[23:16] !== 8'hA5) begin
            fails++;
            $display("FAIL write_a2_slice got 0x%0h required 0xa5", regs_o[23:16]);
        end
        do_read("read_a2", 7'd2, 20);
        do_read("read_a3_resetval", 7'd3, 20);
    endtask

    task automatic test_bad_frames();
        int eb;
        eb = err_cnt;
        xfer("short_12", 12, frame(1'b1, 7'd0, 8'h3C) >> 4, 1'b0, 20, -1);
        check_after("short_12", eb, 1);
        eb = err_cnt;
        xfer("long_17", 17, {frame(1'b1, 7'd1, 8'h77), 1'b1}, 1'b0, 20, -1);
        check_after("long_17", eb, 1);
        eb = err_cnt;
        xfer("empty", 0, 64'd0, 1'b0, 20, -1);
        check_after("empty", eb, 0);
        do_write("write_a7f", 7'h7F, 8'hFF, 20);
        do_read("read_a7f", 7'h7F, 20);
    endtask

    task automatic test_reset_midframe();
        int eb;
        xfer("abort_a3", FLEN, frame(1'b1, 7'd3, 8'h11), 1'b0, 20, 10);
        exp_regs = RST_IMG;
        eb = err_cnt;
        check_after("abort_a3", eb, 0);
        do_write("write_a3_after_rst", 7'd3, 8'hC3, 20);
        do_read("read_a3_after_rst", 7'd3, 20);
    endtask

    task automatic test_back_to_back();
        do_write("b2b_write_a4", 7'd4, 8'h96, MIN_GAP);
        do_read("b2b_read_a4", 7'd4, MIN_GAP);
        for (int k = 0; k < 3; k++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            do_write("b2b_write_rand", a, DATA_W'($urandom), MIN_GAP);
            do_read("b2b_read_rand", a, MIN_GAP);
        end
        do_read("b2b_read_a1", 7'd1, 20);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bad_frames();
        test_reset_midframe();
        test_back_to_back();
        wait_clks(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1, "timeout");
    end
endmodule
